// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the 5-bit ADD/SUB ALU.
// A request is accepted in IDLE, evaluated in EXEC and reported in DONE.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [4:0] a0,
    input  logic [4:0] b0,
    input  logic       op0,
    input  logic [4:0] a1,
    input  logic [4:0] b1,
    input  logic       op1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [4:0] result,
    output logic       carry,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       ptr_q;
    logic       any_req;
    logic       accept;
    logic       win_d;

    logic       win_p0;
    logic [4:0] a_p0;
    logic [4:0] b_p0;
    logic       op_p0;

    // SUB is a + ~b + 1; bit 5 is the carry out (1 = no borrow).
    function automatic logic [5:0] alu_sum(input logic [4:0] a,
                                           input logic [4:0] b,
                                           input logic       op);
        logic [5:0] b_ext;
        b_ext = {1'b0, (op ? ~b : b)};
        return {1'b0, a} + b_ext + {5'd0, op};
    endfunction

    assign any_req = req0 | req1;
    assign accept  = (state_q == IDLE) && any_req;

    always_comb begin
        state_d = state_q;
        win_d   = 1'b0;
        if (req0 && req1) begin
            win_d = ptr_q;
        end else begin
            win_d = req1;
        end
        case (state_q)
            IDLE:    if (any_req) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q <= ~win_d;
            end
        end
    end

    // Stage p0: operand capture on the acceptance edge
    always_ff @(posedge clk) begin
        if (accept) begin
            win_p0 <= win_d;
            a_p0   <= win_d ? a1  : a0;
            b_p0   <= win_d ? b1  : b0;
            op_p0  <= win_d ? op1 : op0;
        end
    end

    // Stage p1: ALU evaluation, result held until the next operation
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= 5'd0;
            carry  <= 1'b0;
        end else if (state_q == EXEC) begin
            {carry, result} <= alu_sum(a_p0, b_p0, op_p0);
        end
    end

    assign gnt0  = (state_q == EXEC) && !win_p0;
    assign gnt1  = (state_q == EXEC) &&  win_p0;
    assign done0 = (state_q == DONE) && !win_p0;
    assign done1 = (state_q == DONE) &&  win_p0;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a transaction-level model predicts
// grant/done pulses and status per edge; a monitor compares after each edge.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst, req0, req1, op0, op1;
    logic [4:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, done0, done1, carry, busy;
    logic [4:0] result;

    alu_arbiter dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .carry(carry), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int e; logic [3:0] p; } ev_t;
    typedef struct { int e; logic busy; logic [4:0] res; logic car; } st_t;

    ev_t ev_q[$];
    st_t st_q[$];

    int ec = 0;
    always @(posedge clk) ec <= ec + 1;

    int n_vec = 0;
    int n_err = 0;

    // model state: operation phase countdown, pointer, latched operation
    int m_left = 0;
    bit m_ptr  = 1'b0;
    bit m_win  = 1'b0;
    int m_a, m_b;
    bit m_op;
    int m_res  = 0;
    bit m_car  = 1'b0;
    bit pend0  = 1'b0;
    bit pend1  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, ec, act, exp);
        end
    endtask

    // Predicts what the DUT shows right after the next rising edge.
    task automatic model_edge();
        int e;
        int s;
        e = ec + 1;
        if (rst) begin
            m_left = 0; m_ptr = 1'b0; m_res = 0; m_car = 1'b0;
        end else if (m_left == 2) begin
            if (!m_op) begin
                s = m_a + m_b;
                m_res = s % 32;
                m_car = (s >= 32);
            end else begin
                m_res = (m_a - m_b + 32) % 32;
                m_car = (m_a >= m_b);
            end
            ev_q.push_back('{e: e, p: (m_win ? 4'b1000 : 4'b0100)});
            m_left = 1;
        end else if (m_left == 1) begin
            m_left = 0;
        end else if (req0 || req1) begin
            m_win = (req0 && req1) ? m_ptr : req1;
            if (!m_win) begin
                m_a = a0; m_b = b0; m_op = op0; pend0 = 1'b0;
            end else begin
                m_a = a1; m_b = b1; m_op = op1; pend1 = 1'b0;
            end
            m_ptr = !m_win;
            m_left = 2;
            ev_q.push_back('{e: e, p: (m_win ? 4'b0010 : 4'b0001)});
        end
        st_q.push_back('{e: e, busy: (m_left != 0), res: m_res[4:0], car: m_car});
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic run_op(input bit port, input int a, input int b, input bit op,
                          input int exp_r, input bit exp_c, input bit poke);
        if (!port) begin
            req0 = 1'b1; a0 = a[4:0]; b0 = b[4:0]; op0 = op;
        end else begin
            req1 = 1'b1; a1 = a[4:0]; b1 = b[4:0]; op1 = op;
        end
        step();
        req0 = 1'b0; req1 = 1'b0;
        if (poke) a0 = 5'd31;
        step();
        check("dir_done", port ? done1 : done0, 1);
        check("dir_result", result, exp_r);
        check("dir_carry", carry, exp_c);
        step();
    endtask

    initial begin : monitor
        ev_t ev;
        st_t st;
        logic [3:0] exp_p;
        forever begin
            @(posedge clk);
            #1;
            exp_p = 4'b0000;
            while (ev_q.size() > 0 && ev_q[0].e < ec) begin
                ev = ev_q.pop_front();
                check("stale_event", 0, 1);
            end
            if (ev_q.size() > 0 && ev_q[0].e == ec) begin
                ev = ev_q.pop_front();
                exp_p = ev.p;
            end
            check("pulses{d1,d0,g1,g0}", {done1, done0, gnt1, gnt0}, exp_p);
            if (st_q.size() > 0 && st_q[0].e == ec) begin
                st = st_q.pop_front();
                check("busy", busy, st.busy);
                check("result", result, st.res);
                check("carry", carry, st.car);
            end
        end
    end

    initial begin : driver
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; op0 = 1'b0; a1 = '0; b1 = '0; op1 = 1'b0;
        step();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_result", result, 0);
        step();

        run_op(1'b0, 5, 3, 1'b0, 8, 1'b0, 1'b0);
        run_op(1'b1, 3, 5, 1'b1, 30, 1'b0, 1'b0);
        run_op(1'b1, 5, 3, 1'b1, 2, 1'b1, 1'b0);
        run_op(1'b0, 20, 15, 1'b0, 3, 1'b1, 1'b0);
        run_op(1'b0, 5, 3, 1'b0, 8, 1'b0, 1'b1);

        // abort during EXEC
        req0 = 1'b1; a0 = 5'd7; b0 = 5'd9; op0 = 1'b0;
        step();
        req0 = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_carry", carry, 0);
        repeat (3) step();

        // both requesters held continuously from reset
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        a0 = 5'd1; b0 = 5'd2; op0 = 1'b0; a1 = 5'd9; b1 = 5'd4; op1 = 1'b1;
        repeat (13) step();
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) step();

        // randomized traffic with occasional resets
        do_reset();
        repeat (600) begin
            rst = ($urandom_range(0, 39) == 0);
            if (!pend0 && $urandom_range(0, 1) == 1) pend0 = 1'b1;
            if (!pend1 && $urandom_range(0, 1) == 1) pend1 = 1'b1;
            req0 = pend0; req1 = pend1;
            a0 = 5'($urandom_range(0, 31)); b0 = 5'($urandom_range(0, 31));
            a1 = 5'($urandom_range(0, 31)); b1 = 5'($urandom_range(0, 31));
            op0 = 1'($urandom_range(0, 1)); op1 = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
        repeat (4) step();
        @(posedge clk);
        #3;
        if (ev_q.size() != 0) check("events_left", ev_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have a single parameter: none; all widths SHALL be fixed at 5-bit operands to match the team's ADD/SUB ALU.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req0 / req1  in  1  requester 0/1 operation request, held high until the matching grant.
REQ-005 a0, b0 / a1, b1  in  5  requester operands, sampled only on the acceptance edge.
REQ-006 op0 / op1  in  1  requester opcode: 0 = ADD (a+b), 1 = SUB (a-b).
REQ-007 gnt0 / gnt1  out  1  one-cycle pulse: the request was accepted and its operands were latched.
REQ-008 done0 / done1  out  1  one-cycle pulse: result and carry are valid for that requester.
REQ-009 result  out  5  registered ALU result, held until the next done.
REQ-010 carry  out  1  registered bit 5 of the 6-bit sum; for SUB, 1 = no borrow.
REQ-011 busy  out  1  high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, EXEC and DONE; the encoding is free.
REQ-013 IDLE, no request: the FSM SHALL remain in IDLE and all pulse outputs SHALL be 0.
REQ-014 IDLE, at least one req high at edge N: the FSM SHALL select the winner and latch its a, b and op; it SHALL go to EXEC, and gntX SHALL be 1 during cycle N+1 only.
REQ-015 Arbitration SHALL be round-robin with a 1-bit priority pointer.
- If only one requester is high, that requester wins.
- If both are high, the pointer's port wins.
- After a requester is served, the pointer SHALL point to the other port.
REQ-016 EXEC: the block SHALL compute sum = {0,a} + {0, op ? ~b : b} + op, all 6 bits wide.
- At the EXEC edge it SHALL register result = sum[4:0] and carry = sum[5].
- It SHALL go to DONE, and doneX for the latched winner SHALL be 1 during cycle N+2.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE; requests are not sampled in EXEC or DONE.
REQ-018 Latency from the request-sampling edge to done SHALL be 2 cycles; peak throughput SHALL be one operation per 3 cycles.
REQ-019 A req still high in IDLE after its own grant SHALL be treated as a new request.
REQ-020 Requester inputs that change during EXEC or DONE SHALL NOT affect the operation in flight.
REQ-021 gnt0/gnt1 SHALL never be high together; the same SHALL hold for done0/done1.
REQ-022 Arithmetic SHALL wrap modulo 32; no overflow flag is produced.

Reset
REQ-023 While rst is high at an edge, the block SHALL set:
- state = IDLE;
- pointer = port 0;
- result = 0, carry = 0;
- gnt0/1, done0/1 and busy = 0.
REQ-024 A reset asserted in EXEC or DONE SHALL abort the operation; no done pulse SHALL follow for it.
REQ-025 rst SHALL take priority over all requests in the same cycle.

Verification
REQ-026 After reset, req0 = 1 with a0 = 5, b0 = 3, op0 = 0 -> gnt0 at N+1, done0 at N+2, result = 8, carry = 0, busy high for 2 cycles.
REQ-027 req1 with a1 = 3, b1 = 5, op1 = 1 -> done1, result = 30 (0x1E), carry = 0; then a1 = 5, b1 = 3, op1 = 1 -> result = 2, carry = 1.
REQ-028 req0 with a0 = 20, b0 = 15, op0 = 0 -> result = 3, carry = 1 (wrap).
REQ-029 req0 and req1 held high continuously from reset -> grants in order 0, 1, 0, 1 at 3-cycle spacing; gnt/done never overlap.
REQ-030 rst asserted during EXEC of a req0 operation -> no done0, and result/carry/busy read 0 on the next cycle.
REQ-031 Change a0 from 5 to 31 in the cycle after gnt0 for op 5+3 -> result is still 8.
